matmul_engine: RTL
==================

Name: matmul_engine

Overview:
- Sequential 3x3 unsigned matrix-multiply engine; computes C = A x B using one shared multiply-accumulate unit, one product per cycle.
- Sits directly upstream of the byte-serial result output stage.
- C0..C8 connect to that stage's 18-bit result inputs. done drives its enable.
- Holds results and done stable until the next start, because the output stage restarts its sequence whenever enable falls.

Parameters:
DATA_W, 8, operand element width. Result width is the derived local constant RES_W = 2*DATA_W+2 (18 at default).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset
start  input  1  single-cycle request; latches operands and begins computation
a_flat  input  9*DATA_W  matrix A, row-major; element A[i][k] at bits [DATA_W*(3i+k) +: DATA_W]
b_flat  input  9*DATA_W  matrix B, row-major; element B[k][j] at bits [DATA_W*(3k+j) +: DATA_W]
C0..C8  output  RES_W each  result C[i][j] on port C(3i+j), registered
busy  output  1  high while computing
done  output  1  high from completion until the next start or reset

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - C0..C8 = 0, busy = 0, done = 0.
  - Internal operand copies, accumulator and counters are cleared.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE, start=1 at edge t0:
  - Latch a_flat and b_flat into internal registers; later input changes have no effect.
  - Clear C0..C8 to 0 and the accumulator.
  - Set i=j=k=0, busy=1, go to COMPUTE.
- COMPUTE, each edge performs one MAC step:
  - sum = acc + A[i][k]*B[k][j], with all arithmetic at RES_W width.
  - k<2: acc <= sum, k <= k+1.
  - k==2: C(3i+j) <= sum, acc <= 0, k <= 0, then advance j 0..2, then i 0..2 (row-major order C0 first, C8 last).
  - Step 27 (i=j=k=2) happens at edge t0+27: it writes C8, sets busy=0, done=1 and moves to DONE.
  - Latency is 27 clocks from the start edge to done high.
  - start during COMPUTE is ignored; no restart and no re-latch.
- DONE:
  - C0..C8 and done are held.
  - start=1 at an edge behaves exactly like start in IDLE: done=0 and busy=1 at that edge, operands re-latched, C cleared, computation restarts.
- Overflow: none possible. Max sum 3*255*255 = 195075 < 2^18.
- Reset mid-COMPUTE aborts immediately: all outputs 0, state IDLE. A subsequent start computes normally.
- busy and done are never high together.

Optional Feature:
MATMUL_SIGNED_EN
- Defined:
  - Operands are two's complement and products are signed.
  - Products and accumulator are sign-extended to RES_W; C0..C8 are two's complement RES_W.
  - Sequencing and timing are unchanged.
- Undefined: all operands, products and results are unsigned, zero-extended.

Test Plan:
1. A = identity, B = [1..9] row-major, start pulse -> at edge t0+27 done=1, busy=0, C0..C8 = 1,2,...,9; busy=1 during edges t0..t0+26.
2. A = [1..9], B = [9..1] -> C0..C8 = 30,24,18,84,69,54,138,114,90; outputs stay stable with done=1 for 100 idle cycles.
3. All A and B elements 255 -> every C = 195075 (0x2FA03), no wrap.
4. start, then change a_flat/b_flat and pulse start again at cycle 5 of COMPUTE -> result matches the first-latched operands and done still rises at edge t0+27. Then pulse start in DONE with new operands -> done=0 on that edge, C cleared, new correct result 27 clocks later.
5. Assert reset at cycle 10 of COMPUTE -> C0..C8=0, busy=0, done=0 immediately without waiting for a clock. Release reset, then scenario 1 passes.
6. With MATMUL_SIGNED_EN, A and B all 0x80 (-128) -> every C = 49152 (0x0C000). A all 0xFF (-1), B = identity -> every C = 0x3FFFF (-1).

Source files
------------

// File: rtl/matmul_engine.sv
// matmul_engine: sequential 3x3 matrix multiply C = A x B using one shared
// multiply-accumulate unit that retires one product per clock. Results and
// done are held until the next start because the downstream byte-serial
// output stage restarts its sequence whenever done falls.
//
// Optional feature macro: MATMUL_SIGNED_EN (two's complement operands and
// results). Undefined: unsigned, zero-extended arithmetic.
//
// Ports:
//   clk            system clock, all state on rising edge
//   reset          asynchronous active-low reset
//   start          single-cycle request; latches operands, begins computation
//   a_flat         matrix A row-major, A[i][k] at [DATA_W*(3i+k) +: DATA_W]
//   b_flat         matrix B row-major, B[k][j] at [DATA_W*(3k+j) +: DATA_W]
//   C0..C8         registered results, C[i][j] on C(3i+j), RES_W bits each
//   busy           high while computing
//   done           high from completion until the next start or reset
module matmul_engine #(
  parameter int unsigned DATA_W = 8,
  localparam int unsigned RES_W = 2 * DATA_W + 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [9*DATA_W-1:0] a_flat,
  input  logic [9*DATA_W-1:0] b_flat,
  output logic [RES_W-1:0]    C0,
  output logic [RES_W-1:0]    C1,
  output logic [RES_W-1:0]    C2,
  output logic [RES_W-1:0]    C3,
  output logic [RES_W-1:0]    C4,
  output logic [RES_W-1:0]    C5,
  output logic [RES_W-1:0]    C6,
  output logic [RES_W-1:0]    C7,
  output logic [RES_W-1:0]    C8,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] a_q [9];
  logic [DATA_W-1:0] b_q [9];
  logic [RES_W-1:0]  c_q [9];
  logic [RES_W-1:0]  acc;
  logic [1:0]        i_q;
  logic [1:0]        j_q;
  logic [1:0]        k_q;

  logic              load;
  logic              last_step;
  logic [3:0]        idx_a;
  logic [3:0]        idx_b;
  logic [3:0]        idx_c;
  logic [DATA_W-1:0] a_el;
  logic [DATA_W-1:0] b_el;
  logic [RES_W-1:0]  prod;
  logic [RES_W-1:0]  sum;

  // Start is honoured only outside COMPUTE; DONE restarts exactly like IDLE.
  assign load      = start && (state_q != COMPUTE);
  assign last_step = (state_q == COMPUTE) && (i_q == 2'd2) && (j_q == 2'd2) && (k_q == 2'd2);

  assign idx_a = 4'(i_q) * 4'd3 + 4'(k_q);
  assign idx_b = 4'(k_q) * 4'd3 + 4'(j_q);
  assign idx_c = 4'(i_q) * 4'd3 + 4'(j_q);
  assign a_el  = a_q[idx_a];
  assign b_el  = b_q[idx_b];

  // Operands are widened to RES_W before multiplying so the product cannot wrap.
`ifdef MATMUL_SIGNED_EN
  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;
  assign a_ext = RES_W'($signed(a_el));
  assign b_ext = RES_W'($signed(b_el));
  assign prod  = a_ext * b_ext;
`else
  assign prod  = RES_W'(a_el) * RES_W'(b_el);
`endif

  assign sum = acc + prod;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = COMPUTE;
      COMPUTE: if (last_step) state_d = DONE;
      DONE:    if (start)     state_d = COMPUTE;
      default:                state_d = IDLE;
    endcase
  end

  // Operand latch, MAC accumulator, loop counters and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 9; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
      acc  <= '0;
      i_q  <= '0;
      j_q  <= '0;
      k_q  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      for (int n = 0; n < 9; n++) begin
        a_q[n] <= a_flat[DATA_W*n +: DATA_W];
        b_q[n] <= b_flat[DATA_W*n +: DATA_W];
        c_q[n] <= '0;
      end
      acc  <= '0;
      i_q  <= '0;
      j_q  <= '0;
      k_q  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (state_q == COMPUTE) begin
      if (k_q == 2'd2) begin
        c_q[idx_c] <= sum;
        acc        <= '0;
        k_q        <= '0;
        if (j_q == 2'd2) begin
          j_q <= '0;
          i_q <= i_q + 2'd1;
        end else begin
          j_q <= j_q + 2'd1;
        end
        if (last_step) begin
          i_q  <= '0;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else begin
        acc <= sum;
        k_q <= k_q + 2'd1;
      end
    end
  end

  assign C0 = c_q[0];
  assign C1 = c_q[1];
  assign C2 = c_q[2];
  assign C3 = c_q[3];
  assign C4 = c_q[4];
  assign C5 = c_q[5];
  assign C6 = c_q[6];
  assign C7 = c_q[7];
  assign C8 = c_q[8];

endmodule
